// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: operation codes,
// FSM states, default widths and the Booth recoding helper.
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH) + 1;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_ADJUST = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NONE = 2'd0,
    BOOTH_ADD  = 2'd1,
    BOOTH_SUB  = 2'd2
  } booth_t;

  // bits = {multiplier LSB, previously shifted-out bit}
  function automatic booth_t booth_recode(input logic [1:0] bits);
    booth_t act;
    case (bits)
      2'b01:   act = BOOTH_ADD;
      2'b10:   act = BOOTH_SUB;
      default: act = BOOTH_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Signed multi-cycle multiply (radix-2 Booth) and restoring divide unit
// producing a 2*WIDTH result split into hi/lo halves for the Z register.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(ITERS) + 1;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               op_r;
  // hi_r: Booth accumulator or partial remainder (one guard bit)
  logic [WIDTH:0]     hi_r;
  // lo_r: multiplier being shifted out, or dividend shifting into quotient
  logic [WIDTH-1:0]   lo_r;
  logic               prev_r;
  logic [WIDTH:0]     m_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   res_hi_r;
  logic [WIDTH-1:0]   res_lo_r;

  booth_t             booth_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     mul_hi_s;
  logic [WIDTH-1:0]   mul_lo_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH:0]     div_hi_s;
  logic [WIDTH-1:0]   div_lo_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   quo_adj_s;
  logic [WIDTH-1:0]   rem_adj_s;

  // Booth add/sub followed by arithmetic shift of {acc, multiplier, prev}
  always_comb begin
    booth_s = booth_recode({lo_r[0], prev_r});
    case (booth_s)
      BOOTH_ADD: sum_s = hi_r + m_r;
      BOOTH_SUB: sum_s = hi_r - m_r;
      default:   sum_s = hi_r;
    endcase
    mul_hi_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
    mul_lo_s = {sum_s[0], lo_r[WIDTH-1:1]};
  end

  // Restoring division step on magnitudes: shift in next dividend bit, trial subtract
  always_comb begin
    shift_s = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
    trial_s = shift_s - m_r;
    if (trial_s[WIDTH] == 1'b0) begin
      div_hi_s = trial_s;
      div_lo_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = shift_s;
      div_lo_s = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Operand magnitudes at start and sign fix-up of the divide results
  always_comb begin
    a_mag_s   = operand_a[WIDTH-1] ? -operand_a : operand_a;
    b_mag_s   = operand_b[WIDTH-1] ? -operand_b : operand_b;
    quo_adj_s = neg_q_r ? -lo_r : lo_r;
    rem_adj_s = neg_r_r ? -hi_r[WIDTH-1:0] : hi_r[WIDTH-1:0];
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      op_r     <= OP_MUL;
      hi_r     <= '0;
      lo_r     <= '0;
      prev_r   <= 1'b0;
      m_r      <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      res_hi_r <= '0;
      res_lo_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r   <= op;
            dbz_r  <= 1'b0;
            busy_r <= 1'b1;
            if ((op == OP_DIV) && (operand_b == '0)) begin
              state_r  <= ST_DONE;
              dbz_r    <= 1'b1;
              done_r   <= 1'b1;
              res_hi_r <= operand_a;
              res_lo_r <= '1;
            end else begin
              state_r <= ST_CALC;
              cnt_r   <= '0;
              hi_r    <= '0;
              prev_r  <= 1'b0;
              neg_q_r <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
              neg_r_r <= operand_a[WIDTH-1];
              if (op == OP_MUL) begin
                m_r  <= {operand_a[WIDTH-1], operand_a};
                lo_r <= operand_b;
              end else begin
                m_r  <= {1'b0, b_mag_s};
                lo_r <= a_mag_s;
              end
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (op_r == OP_MUL) begin
            hi_r   <= mul_hi_s;
            lo_r   <= mul_lo_s;
            prev_r <= lo_r[0];
          end else begin
            hi_r <= div_hi_s;
            lo_r <= div_lo_s;
          end
          if (cnt_r == CNT_W'(ITERS - 1)) begin
            state_r <= ST_ADJUST;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_ADJUST: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
          if (op_r == OP_MUL) begin
            res_hi_r <= hi_r[WIDTH-1:0];
            res_lo_r <= lo_r;
          end else begin
            res_hi_r <= rem_adj_s;
            res_lo_r <= quo_adj_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign result_hi   = res_hi_r;
  assign result_lo   = res_lo_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed vectors.
module tb_mul_div_unit;

  logic        clock;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        div_by_zero;

  int n_checks;
  int n_pass;

  mul_div_unit dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Called at a negedge; returns the number of further negedges until done.
  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic op_i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat, input logic exp_dbz);
    int k;
    @(negedge clock);
    start = 1'b1;
    op = op_i;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h1234_5678;
    @(negedge clock);
    check_val({tag, "_busy"}, {63'd0, busy}, 64'd1);
    check_val({tag, "_dbz_at_start"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    wait_done(k);
    check_val({tag, "_latency"}, 64'(k), 64'(exp_lat));
    check_val({tag, "_hi"}, {32'd0, result_hi}, {32'd0, exp_hi});
    check_val({tag, "_lo"}, {32'd0, result_lo}, {32'd0, exp_lo});
    check_val({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    @(negedge clock);
    check_val({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    check_val({tag, "_hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int k;
    int dcount;
    n_checks = 0;
    n_pass = 0;
    clear = 1'b1;
    start = 1'b0;
    op = 1'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    repeat (2) @(negedge clock);
    check_val("reset_state", {59'd0, busy, done, div_by_zero, 2'd0}, 64'd0);
    check_val("reset_result", {result_hi, result_lo}, 64'd0);
    clear = 1'b0;

    run_op("mul_7_m3",    1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 1'b0);
    run_op("mul_m1_m1",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33, 1'b0);
    run_op("div_100_7",   1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b0);
    run_op("div_m100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 33, 1'b0);
    run_op("div_100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 33, 1'b0);
    run_op("div_5_0",     1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0,  1'b1);
    run_op("div_after_z", 1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b0);
    run_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 1'b0);

    // start while busy is ignored
    @(negedge clock);
    start = 1'b1;
    op = 1'b0;
    operand_a = 32'd3;
    operand_b = 32'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1;
    operand_a = 32'd9;
    operand_b = 32'd9;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    wait_done(k);
    check_val("ctl_done_seen", 64'(k < 60), 64'd1);
    check_val("ctl_result", {result_hi, result_lo}, 64'd12);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) dcount++;
    end
    check_val("ctl_no_queue", 64'(dcount), 64'd0);

    // clear mid-calculation
    @(negedge clock);
    start = 1'b1;
    operand_a = 32'd5;
    operand_b = 32'd6;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    check_val("clr_flags", {62'd0, busy, done}, 64'd0);
    check_val("clr_result", {result_hi, result_lo}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    check_val("clr_no_done", 64'(dcount), 64'd0);

    run_op("mul_2_3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 33, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
